// File: rtl/pipe_ctrl_pkg.sv
// ============================================================
// pipe_ctrl_pkg: opcodes, ALU codes and control-word layout
// Rev 1.0
// ============================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int CTRL_W     = 12;
  localparam int MEM_CTRL_W = 5;
  localparam int WB_CTRL_W  = 3;

  // Control word: {alu_op[2:0],se_op,eq_bra,gt_bra,le_bra,mem_read,mem_write,mem_to_reg[1:0],reg_write}
  localparam int ALU_LSB = 9;
  localparam int SE_BIT  = 8;
  localparam int EQ_BIT  = 7;
  localparam int GT_BIT  = 6;
  localparam int LE_BIT  = 5;
  localparam int MRD_BIT = 4;
  localparam int MWR_BIT = 3;
  localparam int M2R_LSB = 1;
  localparam int RW_BIT  = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_BEQ  = 4'h2;
  localparam logic [3:0] OP_BGT  = 4'h3;
  localparam logic [3:0] OP_BLE  = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_ILL  = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_AND  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_ADDI = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_SLL  = 4'hE;
  localparam logic [3:0] OP_OR   = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_LINK = 2'b10;

  localparam logic [CTRL_W-1:0] NOP_CTRL = '0;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2,
    DST_LINK = 2'd3
  } dst_sel_e;

  typedef enum logic [1:0] {
    ADV_NORMAL   = 2'd0,
    ADV_FREEZE   = 2'd1,
    ADV_FLUSH    = 2'd2,
    ADV_LOAD_USE = 2'd3
  } adv_e;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================
// ctrl_decode: combinational ID-stage opcode decoder
// Rev 1.0
// ============================================================
`default_nettype none

module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic              i_valid,
  input  logic [OP_W-1:0]   i_opcode,
  output logic [CTRL_W-1:0] o_ctrl,
  output dst_sel_e          o_dst_sel,
  output logic              o_reads_rt,
  output logic              o_is_mc,
  output logic              o_is_jump,
  output logic              o_illegal
);

  logic [3:0] w_op;
  logic       w_hi_bad;
  logic       w_illegal;
  logic [2:0] w_alu;
  logic       w_se;
  logic [2:0] w_br;
  logic       w_mrd;
  logic       w_mwr;
  logic [1:0] w_m2r;
  logic       w_rw;

  assign w_op = i_opcode[3:0];

  generate
    if (OP_W > 4) begin : g_wide_op
      assign w_hi_bad = |i_opcode[OP_W-1:4];
    end else begin : g_narrow_op
      assign w_hi_bad = 1'b0;
    end
  endgenerate

  assign w_illegal = w_hi_bad | (w_op == OP_ILL);
  assign o_illegal = i_valid & w_illegal;

  always_comb begin
    w_alu      = ALU_ADD;
    w_se       = 1'b0;
    w_br       = 3'b000;
    w_mrd      = 1'b0;
    w_mwr      = 1'b0;
    w_m2r      = M2R_ALU;
    w_rw       = 1'b0;
    o_dst_sel  = DST_NONE;
    o_reads_rt = 1'b0;
    o_is_mc    = 1'b0;
    o_is_jump  = 1'b0;
    if (i_valid && !w_illegal) begin
      case (w_op)
        OP_JMP:  o_is_jump = 1'b1;
        OP_BEQ:  begin w_alu = ALU_SUB; w_br = 3'b100; o_reads_rt = 1'b1; end
        OP_BGT:  begin w_alu = ALU_SUB; w_br = 3'b010; o_reads_rt = 1'b1; end
        OP_BLE:  begin w_alu = ALU_SUB; w_br = 3'b001; o_reads_rt = 1'b1; end
        OP_LW:   begin
          w_se = 1'b1; w_mrd = 1'b1; w_m2r = M2R_MEM; w_rw = 1'b1; o_dst_sel = DST_RT;
        end
        OP_SW:   begin w_se = 1'b1; w_mwr = 1'b1; o_reads_rt = 1'b1; end
        OP_ADD:  begin w_rw = 1'b1; o_dst_sel = DST_RD; o_reads_rt = 1'b1; end
        OP_SUB:  begin w_alu = ALU_SUB; w_rw = 1'b1; o_dst_sel = DST_RD; o_reads_rt = 1'b1; end
        OP_AND:  begin w_alu = ALU_AND; w_rw = 1'b1; o_dst_sel = DST_RD; o_reads_rt = 1'b1; end
        OP_JAL:  begin
          w_m2r = M2R_LINK; w_rw = 1'b1; o_dst_sel = DST_LINK; o_is_jump = 1'b1;
        end
        OP_ADDI: begin w_se = 1'b1; w_rw = 1'b1; o_dst_sel = DST_RT; end
        OP_MUL:  begin
          w_alu = ALU_MUL; w_rw = 1'b1; o_dst_sel = DST_RD; o_reads_rt = 1'b1; o_is_mc = 1'b1;
        end
        OP_SLL:  begin w_alu = ALU_SLL; w_rw = 1'b1; o_dst_sel = DST_RD; o_reads_rt = 1'b1; end
        OP_OR:   begin w_alu = ALU_OR;  w_rw = 1'b1; o_dst_sel = DST_RD; o_reads_rt = 1'b1; end
        default: ;
      endcase
    end
    o_ctrl = {w_alu, w_se, w_br, w_mrd, w_mwr, w_m2r, w_rw};
  end

endmodule

`default_nettype wire

// File: rtl/pipe_control_unit.sv
// ============================================================
// pipe_control_unit: pipelined control, hazards and MC freeze
// Rev 1.0
// ============================================================
`default_nettype none

module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int REG_AW    = 4,
  parameter int MC_CYCLES = 3,
  parameter int LINK_REG  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [OP_W-1:0]       id_opcode,
  input  logic [REG_AW-1:0]     id_rs,
  input  logic [REG_AW-1:0]     id_rt,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic                  ex_br_taken,
  output logic                  stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  illegal_op,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [REG_AW-1:0]     ex_dst,
  output logic [MEM_CTRL_W-1:0] mem_ctrl,
  output logic [REG_AW-1:0]     mem_dst,
  output logic [WB_CTRL_W-1:0]  wb_ctrl,
  output logic [REG_AW-1:0]     wb_dst,
  output logic                  mc_busy
);

  localparam int MC_W = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;

  logic [CTRL_W-1:0]     w_dec_ctrl;
  dst_sel_e              w_dec_sel;
  logic                  w_reads_rt;
  logic                  w_is_mc;
  logic                  w_is_jump;
  logic [REG_AW-1:0]     w_dec_dst;
  logic                  w_ex_is_branch;
  logic                  w_ex_is_mul;
  logic                  w_load_use;
  adv_e                  w_adv;

  logic [CTRL_W-1:0]     r_ex_ctrl;
  logic [REG_AW-1:0]     r_ex_dst;
  logic [MEM_CTRL_W-1:0] r_mem_ctrl;
  logic [REG_AW-1:0]     r_mem_dst;
  logic [WB_CTRL_W-1:0]  r_wb_ctrl;
  logic [REG_AW-1:0]     r_wb_dst;
  logic [MC_W-1:0]       r_mc_cnt;

  ctrl_decode #(
    .OP_W (OP_W)
  ) u_decode (
    .i_valid    (id_valid),
    .i_opcode   (id_opcode),
    .o_ctrl     (w_dec_ctrl),
    .o_dst_sel  (w_dec_sel),
    .o_reads_rt (w_reads_rt),
    .o_is_mc    (w_is_mc),
    .o_is_jump  (w_is_jump),
    .o_illegal  (illegal_op)
  );

  always_comb begin
    w_dec_dst = '0;
    case (w_dec_sel)
      DST_RD:   w_dec_dst = id_rd;
      DST_RT:   w_dec_dst = id_rt;
      DST_LINK: w_dec_dst = REG_AW'(LINK_REG);
      default:  w_dec_dst = '0;
    endcase
  end

  assign w_ex_is_branch = |r_ex_ctrl[LE_BIT +: 3];
  assign w_ex_is_mul    = (r_ex_ctrl[ALU_LSB +: 3] == ALU_MUL);

  // Hazard only against a real ID instruction; rs is always treated as read.
  assign w_load_use = r_ex_ctrl[MRD_BIT] & id_valid &
                      ((r_ex_dst == id_rs) | (w_reads_rt & (r_ex_dst == id_rt)));

  always_comb begin
    w_adv = ADV_NORMAL;
    if (r_mc_cnt != '0)                     w_adv = ADV_FREEZE;
    else if (ex_br_taken && w_ex_is_branch) w_adv = ADV_FLUSH;
    else if (w_load_use)                    w_adv = ADV_LOAD_USE;
  end

  assign stall       = (w_adv == ADV_FREEZE) | (w_adv == ADV_LOAD_USE);
  assign id_ex_flush = (w_adv == ADV_FLUSH);
  // A jump held in ID by a stall flushes IF/ID only once it actually advances.
  assign if_id_flush = (w_adv == ADV_FLUSH) | ((w_adv == ADV_NORMAL) & w_is_jump);
  assign mc_busy     = w_ex_is_mul & (r_mc_cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_ctrl  <= NOP_CTRL;
      r_ex_dst   <= '0;
      r_mem_ctrl <= '0;
      r_mem_dst  <= '0;
      r_wb_ctrl  <= '0;
      r_wb_dst   <= '0;
      r_mc_cnt   <= '0;
    end else begin
      r_wb_ctrl <= r_mem_ctrl[WB_CTRL_W-1:0];
      r_wb_dst  <= r_mem_dst;
      case (w_adv)
        ADV_FREEZE: begin
          r_mem_ctrl <= '0;
          r_mem_dst  <= '0;
          r_mc_cnt   <= r_mc_cnt - MC_W'(1);
        end
        ADV_FLUSH, ADV_LOAD_USE: begin
          r_ex_ctrl  <= NOP_CTRL;
          r_ex_dst   <= '0;
          r_mem_ctrl <= r_ex_ctrl[MEM_CTRL_W-1:0];
          r_mem_dst  <= r_ex_dst;
        end
        default: begin
          r_ex_ctrl  <= w_dec_ctrl;
          r_ex_dst   <= w_dec_dst;
          r_mem_ctrl <= r_ex_ctrl[MEM_CTRL_W-1:0];
          r_mem_dst  <= r_ex_dst;
          r_mc_cnt   <= w_is_mc ? MC_W'(MC_CYCLES - 1) : '0;
        end
      endcase
    end
  end

  assign ex_ctrl  = r_ex_ctrl;
  assign ex_dst   = r_ex_dst;
  assign mem_ctrl = r_mem_ctrl;
  assign mem_dst  = r_mem_dst;
  assign wb_ctrl  = r_wb_ctrl;
  assign wb_dst   = r_wb_dst;

endmodule

`default_nettype wire
